// File: rtl/wb_stage_if.sv
// Bundle between the memory-access stage and the write-back stage, including the
// register-file write port and forwarding copy that leave the stage.
interface wb_stage_if;
  logic        cmd_ld_wb;
  logic [2:0]  ld_code_wb;
  logic [4:0]  rd_adr_wb;
  logic [31:0] rd_data_wb;
  logic        wbk_rd_reg_wb;
  logic [31:0] ld_data_wb;
  logic        retire_wb;
  logic        stall;
  logic        rst_pipe_wb;
  logic        rf_we;
  logic [4:0]  rf_wadr;
  logic [31:0] rf_wdata;
  logic        wbk_rd_reg_fw;
  logic [4:0]  rd_adr_fw;
  logic [31:0] rd_data_fw;
  logic [63:0] instret;

  modport master (
    output cmd_ld_wb, ld_code_wb, rd_adr_wb, rd_data_wb, wbk_rd_reg_wb,
           ld_data_wb, retire_wb, stall, rst_pipe_wb,
    input  rf_we, rf_wadr, rf_wdata, wbk_rd_reg_fw, rd_adr_fw, rd_data_fw, instret
  );

  modport slave (
    input  cmd_ld_wb, ld_code_wb, rd_adr_wb, rd_data_wb, wbk_rd_reg_wb,
           ld_data_wb, retire_wb, stall, rst_pipe_wb,
    output rf_we, rf_wadr, rf_wdata, wbk_rd_reg_fw, rd_adr_fw, rd_data_fw, instret
  );
endinterface

// File: rtl/wb_stage.sv
// RV32I write-back stage: load formatting with stall-safe load hold, register-file
// write port, one-cycle forwarding copy and the 64-bit retired-instruction counter.
module wb_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  bus
);

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_code_e;

  logic        stall_dly_q, stall_dly_d;
  logic [31:0] ld_hold_q,   ld_hold_d;
  logic [63:0] instret_q,   instret_d;
  logic        stall_1shot;
  logic [31:0] ld_raw;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic        rf_we;
  logic [31:0] rf_wdata;

  // The raw load word is only present for one cycle; a stall that starts in that
  // cycle freezes a private copy, which then feeds the completion write.
  assign stall_1shot = bus.stall & ~stall_dly_q;
  assign ld_raw      = stall_dly_q ? ld_hold_q : bus.ld_data_wb;
  assign off         = bus.rd_data_wb[1:0];

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    stall_dly_d = bus.stall;
    ld_hold_d   = ld_hold_q;
    if (bus.rst_pipe_wb)
      ld_hold_d = 32'd0;
    else if (stall_1shot)
      ld_hold_d = bus.ld_data_wb;

    instret_d = instret_q;
    if (bus.retire_wb && !bus.stall && !bus.rst_pipe_wb)
      instret_d = instret_q + 64'd1;
  end

  always_comb begin
    ld_byte = ld_raw[{off, 3'b000} +: 8];
    ld_half = off[1] ? ld_raw[31:16] : ld_raw[15:0];
    ld_fmt  = 32'd0;
    case (ld_code_e'(bus.ld_code_wb))
      LD_LB:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_fmt = {24'd0, ld_byte};
      LD_LH:   ld_fmt = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_fmt = {16'd0, ld_half};
      LD_LW:   ld_fmt = ld_raw;
      default: ld_fmt = 32'd0;
    endcase
  end

  assign rf_wdata = bus.cmd_ld_wb ? ld_fmt : bus.rd_data_wb;
  assign rf_we    = bus.wbk_rd_reg_wb & (bus.rd_adr_wb != 5'd0) & ~bus.rst_pipe_wb;

  assign bus.rf_we    = rf_we;
  assign bus.rf_wadr  = bus.rd_adr_wb;
  assign bus.rf_wdata = rf_wdata;
  assign bus.instret  = instret_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of block ordering.
  // NOTE: ld_hold is a single register, not a memory, so it is cleared by rst_n
  // like the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_dly_q <= 1'b0;
      ld_hold_q   <= 32'd0;
      instret_q   <= 64'd0;
    end else begin
      stall_dly_q <= stall_dly_d;
      ld_hold_q   <= ld_hold_d;
      instret_q   <= instret_d;
    end
  end

  generate
    if (FWD_EN) begin : g_fwd
      logic        fw_valid_q, fw_valid_d;
      logic [4:0]  fw_adr_q,   fw_adr_d;
      logic [31:0] fw_data_q,  fw_data_d;

      always_comb begin
        fw_valid_d = rf_we;
        fw_adr_d   = bus.rd_adr_wb;
        fw_data_d  = rf_wdata;
        if (bus.rst_pipe_wb) begin
          fw_valid_d = 1'b0;
          fw_adr_d   = 5'd0;
          fw_data_d  = 32'd0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fw_valid_q <= 1'b0;
          fw_adr_q   <= 5'd0;
          fw_data_q  <= 32'd0;
        end else begin
          fw_valid_q <= fw_valid_d;
          fw_adr_q   <= fw_adr_d;
          fw_data_q  <= fw_data_d;
        end
      end

      assign bus.wbk_rd_reg_fw = fw_valid_q;
      assign bus.rd_adr_fw     = fw_adr_q;
      assign bus.rd_data_fw    = fw_data_q;
    end else begin : g_no_fwd
      assign bus.wbk_rd_reg_fw = 1'b0;
      assign bus.rd_adr_fw     = 5'd0;
      assign bus.rd_data_fw    = 32'd0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the write-back rules.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wb_stage_if bus ();

  wb_stage #(.FWD_EN(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit              m_prev_stall;
  logic [31:0]     m_saved;
  bit              m_fw_v;
  logic [4:0]      m_fw_adr;
  logic [31:0]     m_fw_data;
  longint unsigned m_instret;

  task automatic model_reset();
    m_prev_stall = 0;
    m_saved      = '0;
    m_fw_v       = 0;
    m_fw_adr     = '0;
    m_fw_data    = '0;
    m_instret    = 0;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] code, input logic [31:0] word,
                                           input int off);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (code)
      3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h1_0000 : h;
      3'd5:    return h;
      3'd2:    return word;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata();
    logic [31:0] word;
    word = m_prev_stall ? m_saved : bus.ld_data_wb;
    if (bus.cmd_ld_wb) return ref_load(bus.ld_code_wb, word, int'(bus.rd_data_wb % 4));
    return bus.rd_data_wb;
  endfunction

  function automatic bit exp_we();
    return bus.wbk_rd_reg_wb && bus.rd_adr_wb != 0 && !bus.rst_pipe_wb;
  endfunction

  task automatic apply(input bit cmd, input logic [2:0] code, input logic [31:0] rd_data,
                       input logic [4:0] adr, input bit wbk, input logic [31:0] ld,
                       input bit retire, input bit stall, input bit flush);
    bus.cmd_ld_wb     = cmd;
    bus.ld_code_wb    = code;
    bus.rd_data_wb    = rd_data;
    bus.rd_adr_wb     = adr;
    bus.wbk_rd_reg_wb = wbk;
    bus.ld_data_wb    = ld;
    bus.retire_wb     = retire;
    bus.stall         = stall;
    bus.rst_pipe_wb   = flush;
  endtask

  // Called right after a negedge with inputs applied: checks the comb port,
  // clocks once, advances the model, checks the registered outputs.
  task automatic cycle(input string tag);
    bit          we;
    logic [31:0] wd;
    #1;
    we = exp_we();
    wd = exp_wdata();
    check({tag, ".rf_we"},    64'(bus.rf_we),    64'(we));
    check({tag, ".rf_wadr"},  64'(bus.rf_wadr),  64'(bus.rd_adr_wb));
    check({tag, ".rf_wdata"}, 64'(bus.rf_wdata), 64'(wd));
    @(posedge clk);
    if (bus.rst_pipe_wb) begin
      m_fw_v = 0; m_fw_adr = '0; m_fw_data = '0; m_saved = '0;
    end else begin
      m_fw_v = we; m_fw_adr = bus.rd_adr_wb; m_fw_data = wd;
      if (bus.stall && !m_prev_stall) m_saved = bus.ld_data_wb;
    end
    if (bus.retire_wb && !bus.stall && !bus.rst_pipe_wb) m_instret = m_instret + 1;
    m_prev_stall = bus.stall;
    #1;
    check({tag, ".fw_v"},    64'(bus.wbk_rd_reg_fw), 64'(m_fw_v));
    check({tag, ".fw_adr"},  64'(bus.rd_adr_fw),     64'(m_fw_adr));
    check({tag, ".fw_data"}, 64'(bus.rd_data_fw),    64'(m_fw_data));
    check({tag, ".instret"}, bus.instret,            64'(m_instret));
    @(negedge clk);
  endtask

  longint unsigned base;

  initial begin
    model_reset();
    apply(0, 3'd0, 32'd0, 5'd0, 0, 32'd0, 0, 0, 0);
    #12;
    check("reset.fw_v",    64'(bus.wbk_rd_reg_fw), 64'd0);
    check("reset.fw_data", 64'(bus.rd_data_fw),    64'd0);
    check("reset.instret", bus.instret,            64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load formatting
    apply(1, 3'b000, 32'h0000_0103, 5'd3, 1, 32'h8012_3456, 0, 0, 0);
    #1 check("lb.const", 64'(bus.rf_wdata), 64'hFFFF_FF80);
    cycle("lb");
    apply(1, 3'b100, 32'h0000_0103, 5'd3, 1, 32'h8012_3456, 0, 0, 0);
    #1 check("lbu.const", 64'(bus.rf_wdata), 64'h0000_0080);
    cycle("lbu");
    apply(1, 3'b001, 32'h0000_0002, 5'd4, 1, 32'h8001_7FFF, 0, 0, 0);
    #1 check("lh.const", 64'(bus.rf_wdata), 64'hFFFF_8001);
    cycle("lh");
    apply(1, 3'b101, 32'h0000_0000, 5'd4, 1, 32'h8001_7FFF, 0, 0, 0);
    #1 check("lhu.const", 64'(bus.rf_wdata), 64'h0000_7FFF);
    cycle("lhu");
    apply(1, 3'b010, 32'h0000_0003, 5'd4, 1, 32'h8001_7FFF, 0, 0, 0);
    #1 check("lw.const", 64'(bus.rf_wdata), 64'h8001_7FFF);
    cycle("lw");

    // x0 suppression and forwarding copy
    apply(0, 3'b010, 32'h0000_1234, 5'd0, 1, 32'd0, 0, 0, 0);
    #1 check("x0.we", 64'(bus.rf_we), 64'd0);
    cycle("x0");
    apply(0, 3'b010, 32'h0000_1234, 5'd5, 1, 32'd0, 0, 0, 0);
    cycle("x5");
    check("x5.fw.const", {27'd0, bus.wbk_rd_reg_fw, bus.rd_adr_fw, bus.rd_data_fw},
          {27'd0, 1'b1, 5'd5, 32'h0000_1234});

    // Stall hold
    apply(1, 3'b010, 32'd0, 5'd7, 0, 32'hCAFE_BABE, 0, 1, 0);
    cycle("stall0");
    for (int i = 0; i < 4; i++) begin
      apply(1, 3'b010, 32'd0, 5'd7, 0, 32'd0, 0, 1, 0);
      cycle("stallN");
    end
    apply(1, 3'b010, 32'd0, 5'd7, 1, 32'd0, 1, 0, 0);
    #1 check("stall.done.const", 64'(bus.rf_wdata), 64'hCAFE_BABE);
    cycle("stall.done");

    // instret: 10 retiring cycles, 3 stalled
    base = m_instret;
    for (int i = 0; i < 10; i++) begin
      apply(0, 3'd0, 32'd0, 5'd0, 0, 32'd0, 1, (i % 3) == 1, 0);
      cycle("ret");
    end
    check("ret.plus7", bus.instret, 64'(base + 7));

    // Flush with a pending write and retire
    base = m_instret;
    apply(0, 3'd0, 32'h5555_AAAA, 5'd9, 1, 32'd0, 1, 0, 1);
    #1 check("flush.we.const", 64'(bus.rf_we), 64'd0);
    cycle("flush");
    check("flush.fw.const", {27'd0, bus.wbk_rd_reg_fw, bus.rd_adr_fw, bus.rd_data_fw}, 64'd0);
    check("flush.instret.const", bus.instret, 64'(base));

    // Flush coincident with a stall rising edge: the hold stays cleared
    apply(1, 3'b010, 32'd0, 5'd2, 0, 32'h1111_2222, 0, 1, 1);
    cycle("flushstall");
    apply(1, 3'b010, 32'd0, 5'd2, 1, 32'h0, 0, 0, 0);
    #1 check("flushstall.hold.const", 64'(bus.rf_wdata), 64'd0);
    cycle("flushstall.done");

    // Counter wrap
    apply(0, 3'd0, 32'd0, 5'd0, 0, 32'd0, 0, 0, 0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 check("wrap.preload", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    apply(0, 3'd0, 32'd0, 5'd0, 0, 32'd0, 1, 0, 0);
    cycle("wrap");
    check("wrap.zero.const", bus.instret, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0);
      cycle("rand");
    end

    // Async reset in the middle of a stall
    apply(0, 3'd0, 32'hDEAD_0001, 5'd6, 1, 32'd0, 1, 0, 0);
    cycle("prerst");
    apply(1, 3'b010, 32'd0, 5'd6, 1, 32'hBEEF_0000, 1, 1, 0);
    cycle("prerst.stall");
    apply(1, 3'b010, 32'd0, 5'd6, 1, 32'h0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.fw_v",    64'(bus.wbk_rd_reg_fw), 64'd0);
    check("arst.fw_adr",  64'(bus.rd_adr_fw),     64'd0);
    check("arst.fw_data", 64'(bus.rd_data_fw),    64'd0);
    check("arst.instret", bus.instret,            64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(1, 3'b010, 32'd0, 5'd6, 1, 32'h1357_9BDF, 1, 0, 0);
    #1 check("arst.direct.const", 64'(bus.rf_wdata), 64'h1357_9BDF);
    cycle("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the RV32I pipeline. It sits directly downstream of the memory-access stage and consumes its WB-registered controls and the raw load data.
- Formats load data by width, offset and sign.
- Keeps load data valid across data-cache stalls.
- Drives the register-file write port and a one-cycle-delayed forwarding copy for ID/EX hazard bypass.
- Maintains the 64-bit retired-instruction counter.

Parameters:
- FWD_EN, 1, 1 = register the forwarding copy; 0 = tie the *_fw outputs to 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_ld_wb  in  1  instruction in WB is a load
- ld_code_wb  in  3  funct3 of load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rd_adr_wb  in  5  destination register
- rd_data_wb  in  32  ALU result; for loads, the effective address (bits 1:0 = byte offset)
- wbk_rd_reg_wb  in  1  destination-write request
- ld_data_wb  in  32  raw word from data RAM/IO, valid only in the cycle after the MA access
- retire_wb  in  1  a valid instruction completes this cycle
- stall  in  1  pipeline stall (data-cache miss in progress)
- rst_pipe_wb  in  1  pipeline flush for this stage
- rf_we  out  1  register-file write enable
- rf_wadr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- wbk_rd_reg_fw  out  1  forwarding-entry valid
- rd_adr_fw  out  5  forwarding destination
- rd_data_fw  out  32  forwarding data
- instret  out  64  retired-instruction count

Behaviour:
- Stall tracking: stall_dly is stall registered. stall_1shot = stall & ~stall_dly.
- Load hold: ld_hold[31:0] captures ld_data_wb when stall_1shot. ld_raw = stall_dly ? ld_hold : ld_data_wb. ld_hold is not otherwise updated; it is cleared by rst_pipe_wb.
- Formatting, off = rd_data_wb[1:0]:
  - LB/LBU: byte at off; sign-extend bit 7 for LB, zero-extend for LBU.
  - LH/LHU: halfword at off[1], off[0] ignored; sign-extend for LH, zero-extend for LHU.
  - LW: ld_raw as-is, off ignored.
  - Any other code: 32'd0.
- Write data: rf_wdata = cmd_ld_wb ? formatted load : rd_data_wb. Combinational, zero latency.
- Write enable: rf_we = wbk_rd_reg_wb & (rd_adr_wb != 0) & ~rst_pipe_wb. x0 is never written. rf_wadr = rd_adr_wb.
- Stall writes: stall does not gate rf_we. The MA stage drives wbk_rd_reg_wb only on stall completion, and that write must use ld_hold when stall_dly.
- Forwarding registers (FWD_EN=1):
  - Each cycle: wbk_rd_reg_fw <= rf_we, rd_adr_fw <= rf_wadr, rd_data_fw <= rf_wdata.
  - rst_pipe_wb clears all three next cycle.
  - With FWD_EN=0 they are constant 0.
- instret: increments by 1 at a clock edge when retire_wb & ~stall & ~rst_pipe_wb. Wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0. rst_pipe_wb never clears it.
- Reset (async, rst_n low): stall_dly=0, ld_hold=0, wbk_rd_reg_fw=0, rd_adr_fw=0, rd_data_fw=0, instret=0. Combinational outputs follow their inputs.
- Reset mid-stall: state returns to 0 immediately. The first cycle after release uses ld_data_wb directly.
- Simultaneous stall_1shot and rst_pipe_wb: the flush wins and ld_hold=0.
- Back-to-back stalls: each rising edge of stall recaptures ld_hold.

Test Plan:
- LB sign handling: cmd_ld_wb=1, ld_code=000, rd_data_wb=0x..03, ld_data_wb=0x80123456 -> rf_wdata=0xFFFFFF80. Same with code 100 -> 0x00000080.
- LH/LHU at off 2: ld_data_wb=0x8001_7FFF. LH -> 0xFFFF8001; LHU off 0 -> 0x00007FFF. LW -> 0x80017FFF regardless of off.
- x0 suppression: wbk_rd_reg_wb=1, rd_adr_wb=0, rd_data_wb=0x1234 -> rf_we=0, wbk_rd_reg_fw=0 next cycle. rd_adr=5 -> rf_we=1 and fw {1,5,0x1234} one cycle later.
- Stall hold:
  - Stall rises with ld_data_wb=0xCAFEBABE, then ld_data_wb changes to 0 for 4 stall cycles.
  - Completion write with LW asserts wbk_rd_reg_wb.
  - Required: rf_wdata=0xCAFEBABE.
- instret:
  - 10 cycles of retire_wb=1 with stall high on 3 of them -> instret=7.
  - Preload via 2^64-1 increments (or force) -> next retire gives 0.
- Flush/reset:
  - rst_pipe_wb with wbk_rd_reg_wb=1 -> rf_we=0, fw outputs 0 next cycle, instret unchanged.
  - rst_n pulse mid-stall -> all registered outputs 0 asynchronously.
